// File: rtl/romulus_pkg.sv
// Shared constants and FSM state type for the tag serial/parallel block.
package romulus_pkg;

    localparam int TAG_WORDS = 4;
    localparam int WORD_W    = 32;
    localparam int STATE_W   = 128;

    // Index of the terminal tag word (2-bit word counter)
    localparam logic [1:0] LAST_WORD = 2'(TAG_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        VERIFY,
        FIN
    } state_e;

endpackage

// File: rtl/tag_serpar_share_xor_word.sv
// share_xor_word: combinational recombiner, XORs d 32-bit share words into one.
module share_xor_word
    import romulus_pkg::*;
#(
    parameter int d = 2
) (
    input  logic [d*WORD_W-1:0] words_i,
    output logic [WORD_W-1:0]   word_o
);

    // Fold every share word into the running XOR
    always_comb begin
        // NOTE: assign a default before the loop so no path leaves word_o unassigned (no latch).
        word_o = '0;
        for (int k = 0; k < d; k++) begin
            word_o = word_o ^ words_i[k*WORD_W +: WORD_W];
        end
    end

endmodule

// File: rtl/tag_serpar.sv
// tag_serpar: captures the shared final cipher state, then either streams the
// recombined 128-bit tag as four 32-bit words (emit) or checks four received
// words against it (verify).
// Optional build macro TAG_SHARED_OUT_EN: emit mode outputs the raw share words
// (share 0 .. d-1 for each tag word) instead of recombining them.
module tag_serpar
    import romulus_pkg::*;
#(
    parameter int d = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [STATE_W*d-1:0] state_in,
    input  logic                 load,
    input  logic                 verify,
    output logic [WORD_W-1:0]    pdo,
    output logic                 pdo_valid,
    input  logic                 pdo_ready,
    input  logic [WORD_W-1:0]    pdi,
    input  logic                 pdi_valid,
    output logic                 pdi_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 tag_ok
);

    localparam int BUF_W = STATE_W * d;

    state_e                 state_q;
    logic [BUF_W-1:0]       buf_q;
    logic [1:0]             wcnt_q;
    logic [WORD_W-1:0]      diff_q;
    logic                   tag_ok_q;

    logic [d*WORD_W-1:0]    top_flat;
    logic [BUF_W-1:0]       buf_shift;
    logic [WORD_W-1:0]      tw;
    logic [WORD_W-1:0]      emit_word;
    logic [WORD_W-1:0]      diff_next;
    logic                   word_adv;

`ifdef TAG_SHARED_OUT_EN
    localparam int SCNT_W = $clog2(d);
    localparam logic [SCNT_W-1:0] LAST_SHARE = SCNT_W'(d - 1);

    logic [SCNT_W-1:0]      scnt_q;
`endif

    // Gather the current (top) word of every share and the buffer shifted by one word
    always_comb begin
        top_flat  = '0;
        buf_shift = '0;
        for (int k = 0; k < d; k++) begin
            top_flat[k*WORD_W +: WORD_W] = buf_q[k*STATE_W + (STATE_W - WORD_W) +: WORD_W];
            buf_shift[k*STATE_W +: STATE_W] =
                {buf_q[k*STATE_W +: (STATE_W - WORD_W)], {WORD_W{1'b0}}};
        end
    end

    share_xor_word #(
        .d (d)
    ) u_share_xor_word (
        .words_i (top_flat),
        .word_o  (tw)
    );

    assign diff_next = diff_q | (pdi ^ tw);

`ifdef TAG_SHARED_OUT_EN
    // Emit the selected raw share word; advance the tag word only after the last share
    always_comb begin
        emit_word = '0;
        for (int k = 0; k < d; k++) begin
            if (scnt_q == SCNT_W'(k)) begin
                emit_word = top_flat[k*WORD_W +: WORD_W];
            end
        end
        word_adv = (state_q == EMIT) && pdo_ready && (scnt_q == LAST_SHARE);
    end
`else
    // Emit the recombined word; every accepted transfer advances the tag word
    always_comb begin
        emit_word = tw;
        word_adv  = (state_q == EMIT) && pdo_ready;
    end
`endif

    // Control FSM with the share buffer, word counter and mismatch accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the share buffer is reset on purpose so no key-dependent data survives a reset.
            state_q  <= IDLE;
            buf_q    <= '0;
            wcnt_q   <= '0;
            diff_q   <= '0;
            tag_ok_q <= 1'b0;
`ifdef TAG_SHARED_OUT_EN
            scnt_q   <= '0;
`endif
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
            case (state_q)
                IDLE: begin
                    if (load) begin
                        buf_q    <= state_in;
                        wcnt_q   <= '0;
                        diff_q   <= '0;
                        tag_ok_q <= 1'b0;
`ifdef TAG_SHARED_OUT_EN
                        scnt_q   <= '0;
`endif
                        state_q  <= verify ? VERIFY : EMIT;
                    end
                end
                EMIT: begin
`ifdef TAG_SHARED_OUT_EN
                    if (pdo_ready) begin
                        scnt_q <= (scnt_q == LAST_SHARE) ? '0 : scnt_q + SCNT_W'(1);
                    end
`endif
                    if (word_adv) begin
                        buf_q  <= buf_shift;
                        wcnt_q <= wcnt_q + 2'd1;
                        if (wcnt_q == LAST_WORD) begin
                            state_q <= FIN;
                        end
                    end
                end
                VERIFY: begin
                    if (pdi_valid) begin
                        diff_q <= diff_next;
                        buf_q  <= buf_shift;
                        wcnt_q <= wcnt_q + 2'd1;
                        if (wcnt_q == LAST_WORD) begin
                            // Result is ready in the same cycle that done pulses
                            tag_ok_q <= (diff_next == '0);
                            state_q  <= FIN;
                        end
                    end
                end
                FIN: begin
                    buf_q   <= '0;
                    wcnt_q  <= '0;
                    diff_q  <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pdo       = (state_q == EMIT) ? emit_word : '0;
    assign pdo_valid = (state_q == EMIT);
    assign pdi_ready = (state_q == VERIFY);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign tag_ok    = tag_ok_q;

endmodule

// File: tb/tb_tag_serpar.sv
// Directed self-checking bench for tag_serpar (d = 2). Define TAG_SHARED_OUT_EN
// for both bench and RTL to exercise the raw-share emit variant.
module tb_tag_serpar;

    localparam int D = 2;
`ifdef TAG_SHARED_OUT_EN
    localparam int NW = 8;
`else
    localparam int NW = 4;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [255:0]   state_in = '0;
    logic           load = 1'b0;
    logic           verify = 1'b0;
    logic [31:0]    pdo;
    logic           pdo_valid;
    logic           pdo_ready = 1'b0;
    logic [31:0]    pdi = '0;
    logic           pdi_valid = 1'b0;
    logic           pdi_ready;
    logic           busy;
    logic           done;
    logic           tag_ok;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] share0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic [127:0] share1 = 128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F;
    logic [255:0] st_a;
    logic [255:0] st_b = {128'hFFFFFFFF_00000000_12345678_9ABCDEF0,
                          128'h01010101_02020202_03030303_04040404};
    logic [31:0]  tag_words [4];
    logic [31:0]  exp_words [NW];

    tag_serpar #(.d(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .state_in  (state_in),
        .load      (load),
        .verify    (verify),
        .pdo       (pdo),
        .pdo_valid (pdo_valid),
        .pdo_ready (pdo_ready),
        .pdi       (pdi),
        .pdi_valid (pdi_valid),
        .pdi_ready (pdi_ready),
        .busy      (busy),
        .done      (done),
        .tag_ok    (tag_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Load a state at a falling edge; returns at the falling edge after capture
    task automatic do_load(input logic [255:0] st, input logic v);
        @(negedge clk);
        state_in = st;
        verify   = v;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        check("busy_after_load", {31'd0, busy}, 32'd1);
        check("tag_ok_cleared", {31'd0, tag_ok}, 32'd0);
    endtask

    // Collect the emitted words, optionally toggling ready and re-asserting load mid-stream
    task automatic run_emit(input bit toggle, input bit reload, input string name);
        int          idx = 0;
        int          cyc = 0;
        bit          pending = 1'b0;
        logic [31:0] held = '0;
        bit          rdy;
        bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_load(st_a, 1'b0);
        while (idx < NW && cyc < 64) begin
            rdy = toggle ? pat[cyc % 4] : 1'b1;
            pdo_ready = rdy;
            if (reload && cyc == 1) begin
                state_in = st_b;
                load     = 1'b1;
            end else begin
                load     = 1'b0;
            end
            if (pending) begin
                check({name, "_hold_valid"}, {31'd0, pdo_valid}, 32'd1);
                check({name, "_hold_data"}, pdo, held);
            end
            if (pdo_valid) begin
                if (rdy) begin
                    check($sformatf("%s_w%0d", name, idx), pdo, exp_words[idx]);
                    idx++;
                    pending = 1'b0;
                end else begin
                    held    = pdo;
                    pending = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        load      = 1'b0;
        pdo_ready = 1'b0;
        check({name, "_word_count"}, idx, NW);
        if (!toggle) check({name, "_cycles"}, cyc, NW);
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check({name, "_tag_ok"}, {31'd0, tag_ok}, 32'd0);
        check({name, "_valid_off"}, {31'd0, pdo_valid}, 32'd0);
        @(negedge clk);
        check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Feed four received words (with one idle gap) and check the verdict
    task automatic run_verify(input logic [31:0] w2, input logic exp_ok, input string name);
        do_load(st_a, 1'b1);
        check({name, "_pdi_ready"}, {31'd0, pdi_ready}, 32'd1);
        check({name, "_pdo_valid"}, {31'd0, pdo_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                pdi       = 32'hDEADBEEF;
                pdi_valid = 1'b0;
                @(negedge clk);
            end
            pdi       = (i == 2) ? w2 : tag_words[i];
            pdi_valid = 1'b1;
            @(negedge clk);
        end
        pdi_valid = 1'b0;
        pdi       = '0;
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check({name, "_tag_ok"}, {31'd0, tag_ok}, {31'd0, exp_ok});
        @(negedge clk);
        check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({name, "_pdi_ready_off"}, {31'd0, pdi_ready}, 32'd0);
        check({name, "_tag_ok_held"}, {31'd0, tag_ok}, {31'd0, exp_ok});
    endtask

    initial begin
        st_a = {share1, share0};
        tag_words[0] = 32'h0F1E2D3C;
        tag_words[1] = 32'h4B5A6978;
        tag_words[2] = 32'h8796A5B4;
        tag_words[3] = 32'hC3D2E1F0;
`ifdef TAG_SHARED_OUT_EN
        exp_words[0] = 32'h00112233; exp_words[1] = 32'h0F0F0F0F;
        exp_words[2] = 32'h44556677; exp_words[3] = 32'h0F0F0F0F;
        exp_words[4] = 32'h8899AABB; exp_words[5] = 32'h0F0F0F0F;
        exp_words[6] = 32'hCCDDEEFF; exp_words[7] = 32'h0F0F0F0F;
`else
        for (int i = 0; i < 4; i++) exp_words[i] = tag_words[i];
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pdo", pdo, 32'd0);
        check("rst_pdo_valid", {31'd0, pdo_valid}, 32'd0);
        check("rst_pdi_ready", {31'd0, pdi_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_tag_ok", {31'd0, tag_ok}, 32'd0);
        rst_n = 1'b1;

        run_emit(1'b0, 1'b0, "emit");
        run_emit(1'b1, 1'b0, "emit_bp");
        run_verify(32'h8796A5B4, 1'b1, "verify_ok");
        run_emit(1'b0, 1'b1, "emit_reload");
        run_verify(32'h8796A5B5, 1'b0, "verify_bad");

        // Asynchronous reset after two emitted words
        do_load(st_a, 1'b0);
        pdo_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst_word", pdo, exp_words[2]);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pdo", pdo, 32'd0);
        check("mid_rst_valid", {31'd0, pdo_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        pdo_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_emit(1'b0, 1'b0, "emit_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
